// File: rtl/costas_phase_detector_if.sv
`default_nettype none
// ============================================================================
// Module   : costas_phase_detector_if
// Brief    : Sample-in / phase-error-out bundle for the Costas discriminator.
// Revision : 1.0
// ============================================================================
interface costas_phase_detector_if #(
    parameter int IW = 16
);
    logic                 sample_valid;
    logic signed [IW-1:0] i_in;
    logic signed [IW-1:0] q_in;
    logic                 clear;
    logic signed [31:0]   phase_error;
    logic                 phase_valid;
    logic                 locked;

    modport master (
        output sample_valid, i_in, q_in, clear,
        input  phase_error, phase_valid, locked
    );

    modport slave (
        input  sample_valid, i_in, q_in, clear,
        output phase_error, phase_valid, locked
    );
endinterface
`default_nettype wire

// File: rtl/costas_phase_detector.sv
`default_nettype none
// ============================================================================
// Module   : costas_phase_detector
// Brief    : Integrate-and-dump Costas discriminator with hysteretic lock flag.
// Revision : 1.0
// ============================================================================
module costas_phase_detector #(
    parameter int IW       = 16,
    parameter int LOG2N    = 4,
    parameter int MODE     = 0,
    parameter int SHIFT    = 8,
    parameter int LOCK_CNT = 8
) (
    input  wire logic                clk,
    input  wire logic                rst,
    costas_phase_detector_if.slave   bus
);
    localparam int c_aw = IW + LOG2N;
    localparam int c_pw = (2 * c_aw > 33) ? 2 * c_aw : 33;
    localparam logic signed [c_pw-1:0] c_pos_lim = {{(c_pw-32){1'b0}}, 32'h7FFF_FFFF};
    localparam logic signed [c_pw-1:0] c_neg_lim = {{(c_pw-31){1'b1}}, 31'h0};
    localparam logic [7:0]             c_lock_max = 8'(LOCK_CNT);

    logic signed [c_aw-1:0]  w_smp_i, w_smp_q;
    logic signed [c_aw-1:0]  r_acc_i, r_acc_q, r_dump_i, r_dump_q;
    logic [LOG2N-1:0]        r_cnt;
    logic                    r_v1, r_v2, r_v3;
    logic signed [c_pw-1:0]  w_ext_q, w_raw, r_raw, w_shift;
    logic [c_aw-1:0]         w_abs_i, w_abs_q, r_abs_i, r_abs_q;
    logic                    w_qual, r_qual3;
    logic signed [31:0]      w_sat, r_err3, r_phase_error;
    logic                    r_phase_valid, r_locked;
    logic [7:0]              r_lock_cnt, w_lock_nxt;

    assign w_smp_i = {{LOG2N{bus.i_in[IW-1]}}, bus.i_in};
    assign w_smp_q = {{LOG2N{bus.q_in[IW-1]}}, bus.q_in};

    // Stage 1: accumulate; the N-th sample goes straight into the dump latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_i  <= '0;
            r_acc_q  <= '0;
            r_dump_i <= '0;
            r_dump_q <= '0;
            r_cnt    <= '0;
            r_v1     <= 1'b0;
        end else if (bus.clear) begin
            r_acc_i  <= '0;
            r_acc_q  <= '0;
            r_cnt    <= '0;
            r_v1     <= 1'b0;
        end else begin
            r_v1 <= 1'b0;
            if (bus.sample_valid) begin
                r_cnt <= r_cnt + LOG2N'(1);
                if (&r_cnt) begin
                    r_dump_i <= r_acc_i + w_smp_i;
                    r_dump_q <= r_acc_q + w_smp_q;
                    r_acc_i  <= '0;
                    r_acc_q  <= '0;
                    r_v1     <= 1'b1;
                end else begin
                    r_acc_i  <= r_acc_i + w_smp_i;
                    r_acc_q  <= r_acc_q + w_smp_q;
                end
            end
        end
    end

    assign w_ext_q = {{(c_pw-c_aw){r_dump_q[c_aw-1]}}, r_dump_q};
    assign w_abs_i = r_dump_i[c_aw-1] ? -r_dump_i : r_dump_i;
    assign w_abs_q = r_dump_q[c_aw-1] ? -r_dump_q : r_dump_q;

    generate
        if (MODE == 0) begin : g_mode_product
            logic signed [c_pw-1:0] w_ext_i;
            assign w_ext_i = {{(c_pw-c_aw){r_dump_i[c_aw-1]}}, r_dump_i};
            assign w_raw   = w_ext_i * w_ext_q;
            assign w_shift = r_raw >>> SHIFT;
        end else begin : g_mode_sign
            // Wide enough that negating the most-negative Qsum is exact
            assign w_raw   = r_dump_i[c_aw-1] ? -w_ext_q : w_ext_q;
            assign w_shift = r_raw;
        end
    endgenerate

    always_comb begin
        w_sat = w_shift[31:0];
        if (w_shift > c_pos_lim) begin
            w_sat = 32'sh7FFF_FFFF;
        end else if (w_shift < c_neg_lim) begin
            w_sat = 32'sh8000_0000;
        end
    end

    assign w_qual = {1'b0, r_abs_i} > {r_abs_q, 1'b0};

    // Stages 2 and 3: multiply / sign-select, then shift and saturate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_raw   <= '0;
            r_abs_i <= '0;
            r_abs_q <= '0;
            r_err3  <= '0;
            r_qual3 <= 1'b0;
        end else begin
            r_v2 <= r_v1 & ~bus.clear;
            r_v3 <= r_v2 & ~bus.clear;
            if (r_v1) begin
                r_raw   <= w_raw;
                r_abs_i <= w_abs_i;
                r_abs_q <= w_abs_q;
            end
            if (r_v2) begin
                r_err3  <= w_sat;
                r_qual3 <= w_qual;
            end
        end
    end

    always_comb begin
        w_lock_nxt = r_lock_cnt;
        if (r_qual3) begin
            if (r_lock_cnt != c_lock_max) w_lock_nxt = r_lock_cnt + 8'd1;
        end else if (r_lock_cnt != 8'd0) begin
            w_lock_nxt = r_lock_cnt - 8'd1;
        end
    end

    // Output stage: error, strobe and lock flag all move on the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase_error <= '0;
            r_phase_valid <= 1'b0;
            r_lock_cnt    <= '0;
            r_locked      <= 1'b0;
        end else begin
            r_phase_valid <= r_v3 & ~bus.clear;
            if (r_v3 && !bus.clear) begin
                r_phase_error <= r_err3;
                r_lock_cnt    <= w_lock_nxt;
                if (w_lock_nxt == c_lock_max) begin
                    r_locked <= 1'b1;
                end else if (w_lock_nxt == 8'd0) begin
                    r_locked <= 1'b0;
                end
            end
        end
    end

    assign bus.phase_error = r_phase_error;
    assign bus.phase_valid = r_phase_valid;
    assign bus.locked      = r_locked;
endmodule
`default_nettype wire

// File: tb/tb_costas_phase_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_costas_phase_detector
// Brief    : Three DUT flavours (MODE0/SHIFT8, MODE1, MODE0/SHIFT0) vs window model.
// Revision : 1.0
// ============================================================================
module tb_costas_phase_detector;
    localparam int IW = 16;
    localparam int LOG2N = 4;
    localparam int N = 16;
    localparam int LOCKN = 4;
    localparam longint MAXP = 64'sd2147483647;
    localparam longint MINN = -64'sd2147483648;

    typedef struct {
        int     due;
        longint is;
        longint qs;
    } win_t;

    logic clk = 1'b0;
    logic rst;
    logic sv, cl;
    logic signed [IW-1:0] ii, qq;

    always #5 clk = ~clk;

    costas_phase_detector_if #(.IW(IW)) bus0 ();
    costas_phase_detector_if #(.IW(IW)) bus1 ();
    costas_phase_detector_if #(.IW(IW)) bus2 ();

    assign bus0.sample_valid = sv; assign bus0.i_in = ii; assign bus0.q_in = qq; assign bus0.clear = cl;
    assign bus1.sample_valid = sv; assign bus1.i_in = ii; assign bus1.q_in = qq; assign bus1.clear = cl;
    assign bus2.sample_valid = sv; assign bus2.i_in = ii; assign bus2.q_in = qq; assign bus2.clear = cl;

    costas_phase_detector #(.IW(IW), .LOG2N(LOG2N), .MODE(0), .SHIFT(8), .LOCK_CNT(LOCKN))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    costas_phase_detector #(.IW(IW), .LOG2N(LOG2N), .MODE(1), .SHIFT(8), .LOCK_CNT(LOCKN))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    costas_phase_detector #(.IW(IW), .LOG2N(LOG2N), .MODE(0), .SHIFT(0), .LOCK_CNT(LOCKN))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    int     n_vec = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     score = 0;
    logic   exp_lock = 1'b0;
    logic   exp_v = 1'b0;
    longint exp_err[3];
    longint si[$];
    longint sq[$];
    win_t   pend[$];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint ref_err(input int mode, input int sh, input longint is, input longint qs);
        longint r;
        if (mode == 0) r = (is * qs) >>> sh;
        else           r = (is >= 0) ? qs : -qs;
        if (r > MAXP) r = MAXP;
        else if (r < MINN) r = MINN;
        return r;
    endfunction

    function automatic longint labs(input longint x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic model_reset();
        si.delete(); sq.delete(); pend.delete();
        score = 0; exp_lock = 1'b0; exp_v = 1'b0;
        for (int d = 0; d < 3; d++) exp_err[d] = 0;
    endtask

    // Effect of one clock edge given the inputs presented to it
    task automatic model_edge();
        win_t w;
        longint s_i, s_q;
        cyc++;
        exp_v = 1'b0;
        if (cl) begin
            si.delete(); sq.delete(); pend.delete();
        end else begin
            if (pend.size() > 0 && pend[0].due == cyc) begin
                w = pend.pop_front();
                exp_v = 1'b1;
                exp_err[0] = ref_err(0, 8, w.is, w.qs);
                exp_err[1] = ref_err(1, 8, w.is, w.qs);
                exp_err[2] = ref_err(0, 0, w.is, w.qs);
                if (labs(w.is) > 2 * labs(w.qs)) score = (score < LOCKN) ? score + 1 : LOCKN;
                else                              score = (score > 0) ? score - 1 : 0;
                if (score == LOCKN) exp_lock = 1'b1;
                else if (score == 0) exp_lock = 1'b0;
            end
            if (sv) begin
                si.push_back(longint'(ii));
                sq.push_back(longint'(qq));
                if (si.size() == N) begin
                    s_i = 0; s_q = 0;
                    foreach (si[k]) begin s_i += si[k]; s_q += sq[k]; end
                    w.due = cyc + 3; w.is = s_i; w.qs = s_q;
                    pend.push_back(w);
                    si.delete(); sq.delete();
                end
            end
        end
    endtask

    task automatic check_all();
        chk("pv0", bus0.phase_valid, exp_v); chk("pe0", bus0.phase_error, exp_err[0]); chk("lk0", bus0.locked, exp_lock);
        chk("pv1", bus1.phase_valid, exp_v); chk("pe1", bus1.phase_error, exp_err[1]); chk("lk1", bus1.locked, exp_lock);
        chk("pv2", bus2.phase_valid, exp_v); chk("pe2", bus2.phase_error, exp_err[2]); chk("lk2", bus2.locked, exp_lock);
    endtask

    task automatic step(input logic v, input logic signed [IW-1:0] i, input logic signed [IW-1:0] q, input logic c);
        sv = v; ii = i; qq = q; cl = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, '0, 1'b0);
    endtask

    task automatic run_const(input int n, input int i, input int q, input bit toggle);
        for (int k = 0; k < n; k++) begin
            step(1'b1, IW'(i), IW'(q), 1'b0);
            if (toggle) step(1'b0, IW'(-i), IW'(q + 7), 1'b0);
        end
    endtask

    // Asynchronous reset asserted between edges, held across one edge
    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        logic signed [IW-1:0] ri, rq;
        bit bias;
        rst = 1'b1; sv = 1'b0; cl = 1'b0; ii = '0; qq = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        idle(2);

        run_const(2 * N, 1000, 100, 0);
        idle(4);
        run_const(N, -1000, 100, 0);
        run_const(N, 1000, 0, 0);
        idle(4);
        run_const(N, 32767, 32767, 0);
        run_const(N, -32768, 32767, 0);
        run_const(N, -32768, -32768, 0);
        idle(4);

        run_const(6 * N, 1000, 10, 0);
        run_const(4 * N, 10, 1000, 0);
        idle(4);

        run_const(2 * N, 1000, 100, 1);
        idle(4);

        run_const(4 * N, 1000, 10, 0);
        idle(4);
        run_const(7, 1000, 100, 0);
        step(1'b1, 16'sd5000, 16'sd5000, 1'b1);
        run_const(N, 1000, 100, 0);
        idle(4);
        run_const(N, 1000, 100, 0);
        step(1'b0, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b1);
        idle(4);

        run_const(N, 1000, 10, 0);
        idle(2);
        pulse_rst();
        idle(6);

        bias = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (k % 128 == 0) bias = ($urandom % 2) == 1;
            ri = IW'($urandom);
            rq = IW'($urandom);
            if (bias) rq = rq >>> 5;
            step(($urandom % 4) != 0, ri, rq, ($urandom % 64) == 0);
        end
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
